// File: rtl/vram_write_scheduler.sv
// VRAM write scheduler: round-robin CPU/DMA arbitration into the write FIFO,
// and a drain FSM that moves FIFO entries into the VRAM write port.
module vram_write_scheduler #(
    parameter int ADDR_BITS = 17,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cpu_valid,
    input  logic [ADDR_BITS-1:0]           cpu_addr,
    input  logic [DATA_BITS-1:0]           cpu_data,
    output logic                           cpu_ready,
    input  logic                           dma_valid,
    input  logic [ADDR_BITS-1:0]           dma_addr,
    input  logic [DATA_BITS-1:0]           dma_data,
    output logic                           dma_ready,
    output logic [ADDR_BITS+DATA_BITS-1:0] fifo_wr_data,
    output logic                           fifo_wr_en,
    input  logic                           fifo_wr_full,
    input  logic [ADDR_BITS+DATA_BITS-1:0] fifo_rd_data,
    output logic                           fifo_rd_en,
    input  logic                           fifo_rd_empty,
    input  logic                           drain_enable,
    input  logic                           vram_busy,
    output logic                           vram_we,
    output logic [ADDR_BITS-1:0]           vram_addr,
    output logic [DATA_BITS-1:0]           vram_d,
    output logic [FIFO_AW:0]               level,
    output logic                           idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_WRITE
    } state_t;

    localparam logic [FIFO_AW:0] LVL_MAX = {1'b1, {FIFO_AW{1'b0}}};

    state_t           r_state;
    logic             r_last_dma;
    logic [FIFO_AW:0] r_level;

    logic w_cpu_gnt;
    logic w_dma_gnt;
    logic w_push;
    logic w_pop;

    // Handshakes are forced low during reset so a strobe never leaks out of
    // the reset cycle, even though state only clears on the edge.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (!reset && !fifo_wr_full) begin
            if (cpu_valid && dma_valid) begin
                w_cpu_gnt = r_last_dma;
                w_dma_gnt = !r_last_dma;
            end else begin
                w_cpu_gnt = cpu_valid;
                w_dma_gnt = dma_valid;
            end
        end
    end

    assign w_push = w_cpu_gnt || w_dma_gnt;
    assign w_pop  = (r_state == S_WRITE) && !vram_busy && !reset;

    assign cpu_ready    = w_cpu_gnt;
    assign dma_ready    = w_dma_gnt;
    assign fifo_wr_en   = w_push;
    assign fifo_wr_data = w_dma_gnt ? {dma_addr, dma_data} : {cpu_addr, cpu_data};

    assign fifo_rd_en = w_pop;
    assign vram_we    = w_pop;
    assign vram_addr  = fifo_rd_data[ADDR_BITS+DATA_BITS-1:DATA_BITS];
    assign vram_d     = fifo_rd_data[DATA_BITS-1:0];

    assign level = r_level;
    assign idle  = (r_state == S_IDLE) && fifo_rd_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_last_dma <= 1'b1;
            r_level    <= '0;
        end else begin
            if (w_push) begin
                r_last_dma <= w_dma_gnt;
            end

            if (w_push && !w_pop) begin
                if (r_level != LVL_MAX) begin
                    r_level <= r_level + 1'b1;
                end
            end else if (w_pop && !w_push) begin
                if (r_level != '0) begin
                    r_level <= r_level - 1'b1;
                end
            end

            // SETTLE gives the FIFO's registered head one cycle to present data.
            case (r_state)
                S_IDLE: begin
                    if (!fifo_rd_empty && drain_enable) begin
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (fifo_rd_empty || !drain_enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!vram_busy) begin
                        r_state <= S_SETTLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Bench for vram_write_scheduler: behavioural FIFO, queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_write_scheduler;

    localparam int AB    = 17;
    localparam int DB    = 8;
    localparam int FAW   = 9;
    localparam int W     = AB + DB;
    localparam int DEPTH = 1 << FAW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_valid, dma_valid;
    logic [AB-1:0] cpu_addr, dma_addr;
    logic [DB-1:0] cpu_data, dma_data;
    logic          cpu_ready, dma_ready;
    logic [W-1:0]  fifo_wr_data, fifo_rd_data;
    logic          fifo_wr_en, fifo_wr_full, fifo_rd_en, fifo_rd_empty;
    logic          drain_enable, vram_busy, vram_we;
    logic [AB-1:0] vram_addr;
    logic [DB-1:0] vram_d;
    logic [FAW:0]  level;
    logic          idle;

    always #5 clk = ~clk;

    vram_write_scheduler #(
        .ADDR_BITS(AB),
        .DATA_BITS(DB),
        .FIFO_AW  (FAW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_valid    (cpu_valid),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .cpu_ready    (cpu_ready),
        .dma_valid    (dma_valid),
        .dma_addr     (dma_addr),
        .dma_data     (dma_data),
        .dma_ready    (dma_ready),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_full (fifo_wr_full),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_empty(fifo_rd_empty),
        .drain_enable (drain_enable),
        .vram_busy    (vram_busy),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_d       (vram_d),
        .level        (level),
        .idle         (idle)
    );

    // FIFO with registered head read data, sharing the DUT reset.
    logic [W-1:0]   fmem [DEPTH];
    logic [FAW-1:0] fwp, frp;
    logic [FAW:0]   fcnt;
    logic [W-1:0]   f_rd;

    always @(posedge clk) begin
        if (reset) begin
            fwp  <= '0;
            frp  <= '0;
            fcnt <= '0;
            f_rd <= '0;
        end else begin
            f_rd <= fmem[frp];
            if (fifo_wr_en && fcnt != DEPTH) begin
                fmem[fwp] <= fifo_wr_data;
                fwp       <= fwp + 1'b1;
            end
            if (fifo_rd_en && fcnt != 0) frp <= frp + 1'b1;
            if ((fifo_wr_en && fcnt != DEPTH) && !(fifo_rd_en && fcnt != 0)) fcnt <= fcnt + 1'b1;
            else if (!(fifo_wr_en && fcnt != DEPTH) && (fifo_rd_en && fcnt != 0)) fcnt <= fcnt - 1'b1;
        end
    end

    assign fifo_wr_full  = (fcnt == DEPTH);
    assign fifo_rd_empty = (fcnt == 0);
    assign fifo_rd_data  = f_rd;

    // Reference model: queued entries, drain phase (0 idle, 1 settle, 2 write),
    // and which requester won the last accepted transfer.
    logic [W-1:0] mq[$];
    int           mstage;
    bit           mlast_dma;
    int           total;
    int           bad;

    logic          obs_cpu_ready, obs_dma_ready, obs_we, obs_idle;
    logic [AB-1:0] obs_addr;
    logic [DB-1:0] obs_d;
    logic [W-1:0]  obs_wdata;
    logic [FAW:0]  obs_level;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit cv, input logic [AB-1:0] ca, input logic [DB-1:0] cd,
                        input bit dv, input logic [AB-1:0] da, input logic [DB-1:0] dd,
                        input bit de, input bit bz);
        bit ecpu, edma, ewe, was_empty;
        reset        = rst;
        cpu_valid    = cv;
        cpu_addr     = ca;
        cpu_data     = cd;
        dma_valid    = dv;
        dma_addr     = da;
        dma_data     = dd;
        drain_enable = de;
        vram_busy    = bz;
        @(negedge clk);
        obs_cpu_ready = cpu_ready;
        obs_dma_ready = dma_ready;
        obs_we        = vram_we;
        obs_addr      = vram_addr;
        obs_d         = vram_d;
        obs_wdata     = fifo_wr_data;
        obs_level     = level;
        obs_idle      = idle;

        ecpu = 1'b0;
        edma = 1'b0;
        if (!rst && mq.size() < DEPTH) begin
            if (cv && (!dv || mlast_dma)) ecpu = 1'b1;
            else if (dv)                  edma = 1'b1;
        end
        ewe       = !rst && mstage == 2 && !bz;
        was_empty = (mq.size() == 0);

        chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, ecpu});
        chk("dma_ready", {31'd0, dma_ready}, {31'd0, edma});
        chk("fifo_wr_en", {31'd0, fifo_wr_en}, {31'd0, ecpu | edma});
        chk("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, ewe});
        chk("vram_we", {31'd0, vram_we}, {31'd0, ewe});
        if (ecpu) chk("wr_data_cpu", 32'(fifo_wr_data), 32'({ca, cd}));
        if (edma) chk("wr_data_dma", 32'(fifo_wr_data), 32'({da, dd}));
        if (!rst && mstage == 2 && !was_empty) begin
            chk("vram_addr", 32'(vram_addr), 32'(mq[0][W-1:DB]));
            chk("vram_d", 32'(vram_d), 32'(mq[0][DB-1:0]));
        end
        chk("level", 32'(level), 32'(mq.size()));
        chk("idle", {31'd0, idle}, {31'd0, (mstage == 0 && was_empty)});

        if (rst) begin
            mq.delete();
            mstage    = 0;
            mlast_dma = 1'b1;
        end else begin
            case (mstage)
                0:       mstage = (!was_empty && de) ? 1 : 0;
                1:       mstage = (was_empty || !de) ? 0 : 2;
                default: mstage = bz ? 2 : 1;
            endcase
            if (ewe) void'(mq.pop_front());
            if (ecpu) begin mq.push_back({ca, cd}); mlast_dma = 1'b0; end
            if (edma) begin mq.push_back({da, dd}); mlast_dma = 1'b1; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input bit de, input bit bz);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, de, bz);
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_stage(input int s, input bit de, input bit bz);
        for (int i = 0; i < 10 && mstage != s; i++) nop(de, bz);
        chk("reach_stage", 32'(mstage), 32'(s));
    endtask

    initial begin
        int pulses, lastc, gapbad, wes;
        bit de_r;
        total     = 0;
        bad       = 0;
        mstage    = 0;
        mlast_dma = 1'b1;

        // Reset state, then a single CPU write through to VRAM.
        rst_cycles(2);
        chk("rst_level", 32'(obs_level), 32'd0);
        chk("rst_idle", {31'd0, obs_idle}, 32'd1);
        step(1'b0, 1'b1, 17'h1ABCD, 8'h5A, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("t1_ready", {31'd0, obs_cpu_ready}, 32'd1);
        nop(1'b1, 1'b0);
        chk("t1_we_c1", {31'd0, obs_we}, 32'd0);
        chk("t1_level_c1", 32'(obs_level), 32'd1);
        nop(1'b1, 1'b0);
        chk("t1_we_c2", {31'd0, obs_we}, 32'd0);
        nop(1'b1, 1'b0);
        chk("t1_we_c3", {31'd0, obs_we}, 32'd1);
        chk("t1_addr", 32'(obs_addr), 32'h1ABCD);
        chk("t1_data", 32'(obs_d), 32'h5A);
        nop(1'b1, 1'b0);
        chk("t1_level_c4", 32'(obs_level), 32'd0);
        nop(1'b1, 1'b0);
        chk("t1_idle", {31'd0, obs_idle}, 32'd1);

        // Tie for 4 cycles after reset: CPU, DMA, CPU, DMA.
        rst_cycles(1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 17'(32'h00100 + i), 8'(i), 1'b1, 17'(32'h10200 + i), 8'(32'h80 + i), 1'b0, 1'b0);
            chk("t2_cpu_gnt", {31'd0, obs_cpu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("t2_dma_gnt", {31'd0, obs_dma_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i == 0) chk("t2_wdata0", 32'(obs_wdata), 32'h0010000);
            if (i == 1) chk("t2_wdata1", 32'(obs_wdata), 32'h1020181);
        end
        nop(1'b0, 1'b0);
        chk("t2_level", 32'(obs_level), 32'd4);
        for (int i = 0; i < 12; i++) nop(1'b1, 1'b0);
        chk("t2_drained", 32'(obs_level), 32'd0);

        // Fill to capacity, confirm back-pressure, then drain at full rate.
        for (int i = 0; i < 700 && mq.size() < DEPTH; i++)
            step(1'b0, 1'($urandom_range(1)), 17'($urandom), 8'($urandom),
                 1'($urandom_range(1)), 17'($urandom), 8'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'b1, 17'h0AAAA, 8'h11, 1'b1, 17'h05555, 8'h22, 1'b0, 1'b0);
        chk("t3_level_full", 32'(obs_level), 32'd512);
        chk("t3_cpu_blocked", {31'd0, obs_cpu_ready}, 32'd0);
        chk("t3_dma_blocked", {31'd0, obs_dma_ready}, 32'd0);
        pulses = 0;
        lastc  = -1;
        gapbad = 0;
        for (int i = 0; i < 1100 && pulses < 512; i++) begin
            nop(1'b1, 1'b0);
            if (obs_we === 1'b1) begin
                if (lastc >= 0 && i - lastc != 2) gapbad++;
                lastc = i;
                pulses++;
            end
        end
        chk("t3_pulses", 32'(pulses), 32'd512);
        chk("t3_gap", 32'(gapbad), 32'd0);
        for (int i = 0; i < 3; i++) nop(1'b1, 1'b0);

        // VRAM busy for 5 cycles while in WRITE.
        step(1'b0, 1'b1, 17'h0F0F0, 8'h33, 1'b0, '0, '0, 1'b1, 1'b1);
        wait_stage(2, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            nop(1'b1, 1'b1);
            chk("t4_we_held", {31'd0, obs_we}, 32'd0);
            chk("t4_addr_held", 32'(obs_addr), 32'h0F0F0);
            chk("t4_data_held", 32'(obs_d), 32'h33);
        end
        nop(1'b1, 1'b0);
        chk("t4_we_release", {31'd0, obs_we}, 32'd1);
        wes = 0;
        for (int i = 0; i < 6; i++) begin
            nop(1'b1, 1'b0);
            if (obs_we === 1'b1) wes++;
        end
        chk("t4_single_pop", 32'(wes), 32'd0);

        // drain_enable dropped in SETTLE, then in WRITE.
        step(1'b0, 1'b0, '0, '0, 1'b1, 17'h01234, 8'hC3, 1'b0, 1'b0);
        wait_stage(1, 1'b1, 1'b0);
        wes = 0;
        for (int i = 0; i < 3; i++) begin
            nop(1'b0, 1'b0);
            if (obs_we === 1'b1) wes++;
        end
        chk("t5_no_pop", 32'(wes), 32'd0);
        chk("t5_level", 32'(obs_level), 32'd1);
        wait_stage(2, 1'b1, 1'b0);
        nop(1'b0, 1'b0);
        chk("t5_write_done", {31'd0, obs_we}, 32'd1);
        chk("t5_addr", 32'(obs_addr), 32'h01234);
        nop(1'b0, 1'b0);
        nop(1'b0, 1'b0);
        chk("t5_idle", {31'd0, obs_idle}, 32'd1);

        // Reset while in WRITE with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 17'(32'h00300 + i), 8'(i), 1'b0, '0, '0, 1'b0, 1'b0);
        wait_stage(2, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("t6_we_in_reset", {31'd0, obs_we}, 32'd0);
        step(1'b0, 1'b1, 17'h00777, 8'h01, 1'b1, 17'h00888, 8'h02, 1'b0, 1'b0);
        chk("t6_we", {31'd0, obs_we}, 32'd0);
        chk("t6_level", 32'(obs_level), 32'd0);
        chk("t6_idle", {31'd0, obs_idle}, 32'd1);
        chk("t6_tie_cpu", {31'd0, obs_cpu_ready}, 32'd1);

        // Randomized traffic with occasional reset.
        de_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(19) == 0) de_r = !de_r;
            step(($urandom_range(299) == 0),
                 ($urandom_range(2) == 0), 17'($urandom), 8'($urandom),
                 ($urandom_range(2) == 0), 17'($urandom), 8'($urandom),
                 de_r, ($urandom_range(3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
